// File: rtl/wb_xbar_pkg.sv
// wb_xbar_pkg: shared index widths, grant sentinel, arbiter state type and window-match helper for wb_xbar_rr
package wb_xbar_pkg;
  localparam int MAX_NM = 8;
  localparam int MAX_NS = 16;
  localparam int MIDX_W = $clog2(MAX_NM);
  localparam int SIDX_W = $clog2(MAX_NS);
  localparam logic [SIDX_W:0] GRANT_NONE = '1;
  typedef enum logic {IDLE, OWNED} arb_state_e;
  function automatic logic win_hit(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] mask);
    return (addr & mask) == base;
  endfunction
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one slave's round-robin owner register; an owner is held until released
module wb_rr_arbiter
  import wb_xbar_pkg::*;
#(
  parameter int NM = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NM-1:0]     i_req,
  input  logic              i_release,
  output logic [MIDX_W-1:0] o_owner,
  output logic              o_valid
);
  arb_state_e state_q, state_d;
  logic [MIDX_W-1:0] owner_q, owner_d, win;
  int idx;
  // first requester scanning upward from the previous owner, wrapping
  always_comb begin
    win = owner_q;
    idx = 0;
    for (int i = NM; i >= 1; i--) begin
      idx = (int'(owner_q) + i) % NM;
      if (i_req[idx]) win = MIDX_W'(idx);
    end
  end
  // grants are only issued from IDLE, so a release always costs one idle cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q == OWNED) state_d = i_release ? IDLE : OWNED;
    else if (|i_req) begin
      state_d = OWNED;
      owner_d = win;
    end
  end
  // owner doubles as last-owner; reset points it at NM-1 so master 0 leads
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      owner_q <= MIDX_W'(NM - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
  assign o_owner = owner_q;
  assign o_valid = state_q == OWNED;
endmodule

// File: rtl/wb_xbar_rr.sv
// wb_xbar_rr: NM x NS Wishbone classic crossbar with base/mask decode, per-slave round-robin and unmapped bus error; define WB_XBAR_TIMEOUT_EN for a per-slave watchdog
module wb_xbar_rr
  import wb_xbar_pkg::*;
#(
  parameter int NM = 4,
  parameter int NS = 8,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM-1:0]    o_merr,
  output logic [NM*DW-1:0] o_mdata,
  output logic [NS-1:0]    o_scyc,
  output logic [NS-1:0]    o_sstb,
  output logic [NS-1:0]    o_swe,
  output logic [NS*AW-1:0] o_saddr,
  output logic [NS*DW-1:0] o_sdata,
  output logic [NS*SW-1:0] o_ssel,
  input  logic [NS-1:0]    i_sack,
  input  logic [NS-1:0]    i_serr,
  input  logic [NS*DW-1:0] i_sdata
);
  logic [SIDX_W:0] hit_s [NM];
  logic [SIDX_W:0] own_s [NM];
  logic [NM-1:0] req [NS];
  logic [MIDX_W-1:0] gnt [NS];
  logic [NS-1:0] gv, rel, to, own_cyc;
  logic [NM-1:0] merr_q, merr_d;
  // decode each master (lowest slave wins overlaps); masters already owning a slave may not request another
  always_comb begin
    merr_d = '0;
    for (int m = 0; m < NM; m++) begin
      hit_s[m] = GRANT_NONE;
      for (int s = NS - 1; s >= 0; s--)
        if (win_hit(64'(i_maddr[m*AW +: AW]), 64'(SLAVE_BASE[s*AW +: AW]), 64'(SLAVE_MASK[s*AW +: AW])))
          hit_s[m] = (SIDX_W+1)'(s);
      merr_d[m] = i_mcyc[m] & i_mstb[m] & (hit_s[m] == GRANT_NONE) & ~merr_q[m];
    end
    for (int s = 0; s < NS; s++) begin
      req[s] = '0;
      for (int m = 0; m < NM; m++)
        req[s][m] = i_mcyc[m] & i_mstb[m] & (hit_s[m] == (SIDX_W+1)'(s)) & (own_s[m] == GRANT_NONE);
    end
  end
  for (genvar g = 0; g < NS; g++) begin : g_arb
    wb_rr_arbiter #(.NM(NM)) u_arb (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_req    (req[g]),
      .i_release(rel[g]),
      .o_owner  (gnt[g]),
      .o_valid  (gv[g])
    );
  end
  // steer owner signals to each slave and the owned slave's response back to its owner
  always_comb begin
    o_scyc = '0;
    o_sstb = '0;
    o_swe = '0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel = '0;
    o_mack = '0;
    o_merr = '0;
    o_mdata = '0;
    own_cyc = '0;
    for (int m = 0; m < NM; m++) own_s[m] = GRANT_NONE;
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++)
        if (gv[s] && gnt[s] == MIDX_W'(m)) begin
          own_cyc[s] = i_mcyc[m];
          own_s[m] = (SIDX_W+1)'(s);
          o_scyc[s] = i_mcyc[m] & ~to[s];
          o_sstb[s] = i_mstb[m];
          o_swe[s] = i_mwe[m];
          o_saddr[s*AW +: AW] = i_maddr[m*AW +: AW] & ~SLAVE_MASK[s*AW +: AW];
          o_sdata[s*DW +: DW] = i_mdata[m*DW +: DW];
          o_ssel[s*SW +: SW] = i_msel[m*SW +: SW];
          o_mack[m] = i_sack[s];
          o_merr[m] = i_serr[s] | to[s];
          o_mdata[m*DW +: DW] = i_sdata[s*DW +: DW];
        end
    rel = ~own_cyc | to;
    o_merr = o_merr | merr_q;
  end
  // unmapped-access error: one-cycle pulse, never back-to-back
  always_ff @(posedge i_clk) merr_q <= i_reset ? '0 : merr_d;
`ifdef WB_XBAR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q [NS];
  // count stalled strobe cycles of the current owner; any response or release restarts it
  always_ff @(posedge i_clk)
    for (int s = 0; s < NS; s++)
      cnt_q[s] <= (i_reset | rel[s] | i_sack[s] | i_serr[s]) ? '0 : cnt_q[s] + CW'(own_cyc[s] & o_sstb[s]);
  // watchdog fires when the stall count reaches TIMEOUT
  always_comb
    for (int s = 0; s < NS; s++) to[s] = gv[s] && cnt_q[s] == CW'(TIMEOUT);
`else
  assign to = {NS{TIMEOUT < 0}};
`endif
endmodule

// File: tb/tb_wb_xbar_rr.sv
// tb_wb_xbar_rr: directed plan plus random traffic checked every cycle against a cycle-level model of the crossbar rules
module tb_wb_xbar_rr;
  localparam int TMO = 8;
  localparam logic [255:0] BASE = {32'h7000_0000, 32'h6000_0000, 32'h3000_0000, 32'h4000_0000,
                                   32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [255:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
                                   32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  logic clk = 0, rst;
  logic [3:0] mcyc, mstb, mwe, o_mack, o_merr;
  logic [127:0] maddr, mdata, o_mdata;
  logic [15:0] msel;
  logic [7:0] o_scyc, o_sstb, o_swe, sack, serr;
  logic [255:0] o_saddr, o_sdata, sdata;
  logic [31:0] o_ssel;
  logic [7:0] e_scyc, e_sstb, e_swe;
  logic [255:0] e_saddr, e_sdata;
  logic [31:0] e_ssel;
  logic [3:0] e_mack, e_merr;
  logic [127:0] e_mdata;
  int own [8], last [8], cnt [8];
  bit tmo [8];
  bit uerr [4];
  int wt [4];
  int n_tests = 0, n_fail = 0;
  int order [$], at [$];
  int rr_exp [4] = '{0, 1, 2, 0};
  int tk;
  bit m0_pend;
  always #5 clk = ~clk;
  wb_xbar_rr #(.NM(4), .NS(8), .AW(32), .DW(32), .SW(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe), .i_maddr(maddr), .i_mdata(mdata), .i_msel(msel),
    .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe), .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(sack), .i_serr(serr), .i_sdata(sdata)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int dec(input logic [31:0] a);
    for (int s = 0; s < 8; s++) if ((a & MASK[s*32 +: 32]) == BASE[s*32 +: 32]) return s;
    return -1;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin own[s] = -1; last[s] = 3; cnt[s] = 0; tmo[s] = 0; end
    for (int m = 0; m < 4; m++) uerr[m] = 0;
  endtask
  task automatic calc();
    int os [4];
    for (int m = 0; m < 4; m++) os[m] = -1;
    for (int s = 0; s < 8; s++) if (own[s] >= 0) os[own[s]] = s;
    e_scyc = '0; e_sstb = '0; e_swe = '0; e_saddr = '0; e_sdata = '0; e_ssel = '0;
    e_mack = '0; e_merr = '0; e_mdata = '0;
    for (int s = 0; s < 8; s++) begin
      tmo[s] = 0;
`ifdef WB_XBAR_TIMEOUT_EN
      tmo[s] = own[s] >= 0 && cnt[s] == TMO;
`endif
      if (own[s] >= 0) begin
        int m = own[s];
        e_scyc[s] = mcyc[m] & !tmo[s];
        e_sstb[s] = mstb[m];
        e_swe[s] = mwe[m];
        e_saddr[s*32 +: 32] = maddr[m*32 +: 32] & ~MASK[s*32 +: 32];
        e_sdata[s*32 +: 32] = mdata[m*32 +: 32];
        e_ssel[s*4 +: 4] = msel[m*4 +: 4];
      end
    end
    for (int m = 0; m < 4; m++) begin
      if (os[m] >= 0) begin
        e_mack[m] = sack[os[m]];
        e_merr[m] = serr[os[m]] | tmo[os[m]];
        e_mdata[m*32 +: 32] = sdata[os[m]*32 +: 32];
      end
      e_merr[m] = e_merr[m] | uerr[m];
    end
  endtask
  task automatic advance();
    int os [4];
    if (rst) begin model_reset(); return; end
    for (int m = 0; m < 4; m++) os[m] = -1;
    for (int s = 0; s < 8; s++) if (own[s] >= 0) os[own[s]] = s;
    for (int m = 0; m < 4; m++) uerr[m] = mcyc[m] & mstb[m] & (dec(maddr[m*32 +: 32]) < 0) & !uerr[m];
    for (int s = 0; s < 8; s++) begin
      if (own[s] >= 0) begin
        if (!mcyc[own[s]] || tmo[s]) begin own[s] = -1; cnt[s] = 0; end
        else cnt[s] = (sack[s] | serr[s]) ? 0 : cnt[s] + int'(mstb[own[s]]);
      end else begin
        cnt[s] = 0;
        for (int k = 1; k <= 4; k++) begin
          int c = (last[s] + k) % 4;
          if (mcyc[c] && mstb[c] && dec(maddr[c*32 +: 32]) == s && os[c] < 0) begin
            own[s] = c; last[s] = c; break;
          end
        end
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    calc();
    chk("scyc", o_scyc, e_scyc);
    chk("sstb", o_sstb, e_sstb);
    chk("swe", o_swe, e_swe);
    chk("saddr", o_saddr, e_saddr);
    chk("sdata", o_sdata, e_sdata);
    chk("ssel", o_ssel, e_ssel);
    chk("mack", o_mack, e_mack);
    chk("merr", o_merr, e_merr);
    chk("mdata", o_mdata, e_mdata);
    advance();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    mcyc = '0; mstb = '0; sack = '0; serr = '0;
    step();
    step();
  endtask
  task automatic new_addr(input int m);
    logic [31:0] a = $urandom;
    int r = $urandom % 12;
    if (r < 8) a[31:28] = 4'(r);
    else if (r < 10) a[31:28] = 4'(8 + $urandom % 8);
    else a[31:24] = 8'h30;
    maddr[m*32 +: 32] = a;
    mwe[m] = 1'($urandom);
    mdata[m*32 +: 32] = $urandom;
    msel[m*4 +: 4] = 4'($urandom);
  endtask
  initial begin
    rst = 1; mcyc = '0; mstb = '0; mwe = '0; maddr = '0; mdata = '0; msel = '0;
    sack = '0; serr = '0; sdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    rst = 0;
    #1;
    chk("rst_scyc", o_scyc, 0);
    chk("rst_merr", o_merr, 0);
    chk("rst_mack", o_mack, 0);
    chk("rst_mdata", o_mdata, 0);
    maddr[31:0] = 32'h2000_0010; msel[3:0] = 4'hF; mcyc[0] = 1; mstb[0] = 1;
    #1;
    chk("rd_no_stb_yet", o_sstb, 0);
    step();
    chk("rd_stb2", o_sstb, 8'h04);
    chk("rd_saddr", o_saddr[95:64], 32'h10);
    sack[2] = 1; sdata[95:64] = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack0", o_mack, 4'h1);
    chk("rd_data0", o_mdata[31:0], 32'hDEAD_BEEF);
    step();
    idle();
    maddr[31:0] = 32'h1000_0000; maddr[63:32] = 32'h1000_0100; maddr[95:64] = 32'h1000_0200;
    mcyc = 4'b0111; mstb = 4'b0111; m0_pend = 1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      #1;
      sack[1] = o_scyc[1] & o_sstb[1];
      if (sack[1]) begin order.push_back(int'(o_saddr[63:40])); at.push_back(c); end
      step();
      sack[1] = 0;
      if (!mcyc[0] && m0_pend) begin mcyc[0] = 1; mstb[0] = 1; m0_pend = 0; end
      for (int m = 0; m < 3; m++) if (e_mack[m]) begin mcyc[m] = 0; mstb[m] = 0; end
    end
    chk("rr_grants", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++) begin
      chk("rr_order", order[k], rr_exp[k]);
      if (k > 0) chk("rr_gap", at[k] - at[k-1], 3);
    end
    idle();
    maddr[127:96] = 32'h9000_0000; mcyc[3] = 1; mstb[3] = 1;
    #1;
    chk("um_before", o_merr[3], 0);
    step();
    chk("um_err", o_merr, 4'h8);
    chk("um_scyc", o_scyc, 0);
    mcyc[3] = 0; mstb[3] = 0;
    step();
    chk("um_once", o_merr[3], 0);
    idle();
    maddr[63:32] = 32'h0000_0040; mcyc[1] = 1; mstb[1] = 1;
    step();
    chk("rs_owned", o_scyc[0], 1);
    rst = 1; sack[0] = 1;
    step();
    chk("rs_scyc", o_scyc[0], 0);
    chk("rs_ack", o_mack[1], 0);
    rst = 0; sack[0] = 0; maddr[31:0] = 32'h0000_0080; mcyc[0] = 1; mstb[0] = 1;
    step();
    chk("rs_m0_wins", o_saddr[31:0], 32'h80);
    idle();
    maddr[95:64] = 32'h3000_1234; mcyc[2] = 1; mstb[2] = 1;
    step();
    chk("ov_stb", o_sstb, 8'h08);
    chk("ov_saddr", o_saddr[127:96], 32'h1234);
    idle();
    maddr[31:0] = 32'h4000_0000; mcyc[0] = 1; mstb[0] = 1;
    step();
    chk("st_first", o_sstb[4], 1);
`ifdef WB_XBAR_TIMEOUT_EN
    tk = 0;
    for (int k = 1; k <= 20 && tk == 0; k++) begin
      step();
      if (o_merr[0]) begin tk = k; chk("to_scyc", o_scyc[4], 0); end
    end
    chk("to_cycles", tk, TMO);
    step();
    chk("to_freed", o_scyc[4], 0);
`else
    repeat (1000) step();
    chk("stall_stb", o_sstb[4], 1);
    chk("stall_merr", o_merr[0], 0);
`endif
    idle();
    for (int m = 0; m < 4; m++) wt[m] = 0;
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom % 200) == 0;
      for (int m = 0; m < 4; m++) begin
        if (mcyc[m]) begin
          if (e_mack[m] | e_merr[m]) begin
            wt[m] = 0;
            if ($urandom % 3 == 0) new_addr(m);
            else begin mcyc[m] = 0; mstb[m] = 0; end
          end else if (++wt[m] > 25) begin mcyc[m] = 0; mstb[m] = 0; end
          else mstb[m] = ($urandom % 8) != 0;
        end else if ($urandom % 3 == 0) begin
          mcyc[m] = 1; mstb[m] = 1; wt[m] = 0; new_addr(m);
        end
      end
      calc();
      for (int s = 0; s < 8; s++) begin
        int r = $urandom % 10;
        sdata[s*32 +: 32] = $urandom;
        sack[s] = e_scyc[s] & e_sstb[s] & (r < 5 || r == 6);
        serr[s] = e_scyc[s] & e_sstb[s] & (r == 5 || r == 6);
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
